// File: rtl/secded_corrector.sv
// SEC-DED (12,8)+P corrector: registered syndrome stage, then registered decode/correct
// stage, with valid/ready flow control and saturating single/double error counters.
module secded_corrector #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [4:0]       in_check,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_single,
  output logic             out_double,
  output logic [3:0]       out_syndrome,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] single_cnt,
  output logic [CNT_W-1:0] double_cnt
);

  logic             vld_p1_q, vld_p1_d;
  logic [7:0]       data_p1_q, data_p1_d;
  logic [3:0]       syn_p1_q, syn_p1_d;
  logic             pe_p1_q, pe_p1_d;

  logic             vld_p2_q, vld_p2_d;
  logic [7:0]       data_p2_q, data_p2_d;
  logic             single_p2_q, single_p2_d;
  logic             double_p2_q, double_p2_d;
  logic [3:0]       syn_p2_q, syn_p2_d;

  logic [CNT_W-1:0] single_cnt_q, single_cnt_d;
  logic [CNT_W-1:0] double_cnt_q, double_cnt_d;

  logic             s2_load;
  logic             out_fire;

  function automatic logic [3:0] calc_syndrome(input logic [7:0] d, input logic [3:0] c);
    logic [3:0] p;
    p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
    p[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
    return p ^ c;
  endfunction

  // Maps a Hamming position to the data bit it holds; parity positions map to no bit.
  function automatic logic [7:0] flip_mask(input logic [3:0] s);
    logic [7:0] m;
    case (s)
      4'd3:    m = 8'h01;
      4'd5:    m = 8'h02;
      4'd6:    m = 8'h04;
      4'd7:    m = 8'h08;
      4'd9:    m = 8'h10;
      4'd10:   m = 8'h20;
      4'd11:   m = 8'h40;
      4'd12:   m = 8'h80;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  assign s2_load  = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || s2_load;
  assign out_fire = vld_p2_q && out_ready;

  // Stage 1: syndrome and overall parity
  always_comb begin
    vld_p1_d  = vld_p1_q;
    data_p1_d = data_p1_q;
    syn_p1_d  = syn_p1_q;
    pe_p1_d   = pe_p1_q;
    if (in_ready) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        data_p1_d = in_data;
        syn_p1_d  = calc_syndrome(in_data, in_check[3:0]);
        pe_p1_d   = ^{in_data, in_check};
      end
    end
  end

  // Stage 2: decode and correct
  always_comb begin
    vld_p2_d    = vld_p2_q;
    data_p2_d   = data_p2_q;
    single_p2_d = single_p2_q;
    double_p2_d = double_p2_q;
    syn_p2_d    = syn_p2_q;
    if (s2_load) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        data_p2_d   = data_p1_q;
        single_p2_d = 1'b0;
        double_p2_d = 1'b0;
        syn_p2_d    = syn_p1_q;
        if (pe_p1_q) begin
          if (syn_p1_q > 4'd12) begin
            double_p2_d = 1'b1;
          end else begin
            single_p2_d = 1'b1;
            data_p2_d   = data_p1_q ^ flip_mask(syn_p1_q);
          end
        end else if (syn_p1_q != 4'd0) begin
          double_p2_d = 1'b1;
        end
      end
    end
  end

  // Counters: clear beats a same-cycle increment
  always_comb begin
    single_cnt_d = single_cnt_q;
    double_cnt_d = double_cnt_q;
    if (clr_cnt) begin
      single_cnt_d = '0;
      double_cnt_d = '0;
    end else if (out_fire) begin
      if (single_p2_q) single_cnt_d = sat_inc(single_cnt_q);
      if (double_p2_q) double_cnt_d = sat_inc(double_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q     <= 1'b0;
      data_p1_q    <= '0;
      syn_p1_q     <= '0;
      pe_p1_q      <= 1'b0;
      vld_p2_q     <= 1'b0;
      data_p2_q    <= '0;
      single_p2_q  <= 1'b0;
      double_p2_q  <= 1'b0;
      syn_p2_q     <= '0;
      single_cnt_q <= '0;
      double_cnt_q <= '0;
    end else begin
      vld_p1_q     <= vld_p1_d;
      data_p1_q    <= data_p1_d;
      syn_p1_q     <= syn_p1_d;
      pe_p1_q      <= pe_p1_d;
      vld_p2_q     <= vld_p2_d;
      data_p2_q    <= data_p2_d;
      single_p2_q  <= single_p2_d;
      double_p2_q  <= double_p2_d;
      syn_p2_q     <= syn_p2_d;
      single_cnt_q <= single_cnt_d;
      double_cnt_q <= double_cnt_d;
    end
  end

  assign out_valid    = vld_p2_q;
  assign out_data     = data_p2_q;
  assign out_single   = single_p2_q;
  assign out_double   = double_p2_q;
  assign out_syndrome = syn_p2_q;
  assign single_cnt   = single_cnt_q;
  assign double_cnt   = double_cnt_q;

endmodule

// File: tb/tb_secded_corrector.sv
// Directed-vector bench for secded_corrector: table of single words, then back-pressure,
// counter saturation/clear (narrow-counter instance) and mid-flight reset sequences.
module tb_secded_corrector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, in_ready;
  logic [7:0] in_data = '0;
  logic [4:0] in_check = '0;
  logic       out_valid, out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_single, out_double;
  logic [3:0] out_syndrome;
  logic       clr_cnt = 1'b0;
  logic [7:0] single_cnt, double_cnt;

  logic       in_valid2 = 1'b0, in_ready2;
  logic [7:0] in_data2 = '0;
  logic [4:0] in_check2 = '0;
  logic       out_valid2, out_ready2 = 1'b1;
  logic [7:0] out_data2;
  logic       out_single2, out_double2;
  logic [3:0] out_syndrome2;
  logic       clr_cnt2 = 1'b0;
  logic [1:0] single_cnt2, double_cnt2;

  secded_corrector #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_check(in_check),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_single(out_single), .out_double(out_double), .out_syndrome(out_syndrome),
    .clr_cnt(clr_cnt), .single_cnt(single_cnt), .double_cnt(double_cnt)
  );

  secded_corrector #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_check(in_check2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_single(out_single2), .out_double(out_double2), .out_syndrome(out_syndrome2),
    .clr_cnt(clr_cnt2), .single_cnt(single_cnt2), .double_cnt(double_cnt2)
  );

  typedef struct {
    logic [7:0] d;
    logic [4:0] c;
    logic [7:0] exp_d;
    logic       exp_s;
    logic       exp_dbl;
    logic [3:0] exp_syn;
  } vec_t;

  vec_t tv[12];
  int   errors = 0;
  int   checks = 0;
  int   exp_sc = 0;
  int   exp_dc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1 with the pipeline empty and out_ready=1.
  task automatic apply1(input int i);
    in_valid = 1'b1; in_data = tv[i].d; in_check = tv[i].c;
    #1;
    chk($sformatf("v%0d_in_ready", i), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d_not_early", i), out_valid, 0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_out_valid", i), out_valid, 1);
    chk($sformatf("v%0d_data", i), out_data, tv[i].exp_d);
    chk($sformatf("v%0d_single", i), out_single, tv[i].exp_s);
    chk($sformatf("v%0d_double", i), out_double, tv[i].exp_dbl);
    chk($sformatf("v%0d_syn", i), out_syndrome, tv[i].exp_syn);
    exp_sc += int'(tv[i].exp_s);
    exp_dc += int'(tv[i].exp_dbl);
    @(posedge clk); #1;
    chk($sformatf("v%0d_drained", i), out_valid, 0);
    chk($sformatf("v%0d_single_cnt", i), single_cnt, exp_sc);
    chk($sformatf("v%0d_double_cnt", i), double_cnt, exp_dc);
  endtask

  task automatic pass2(input logic clr);
    in_valid2 = 1'b1; in_data2 = 8'hAD; in_check2 = 5'h03;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    for (int w = 0; w < 8 && !out_valid2; w++) begin
      @(posedge clk); #1;
    end
    chk("t5_out_valid", out_valid2, 1);
    chk("t5_out_single", out_single2, 1);
    clr_cnt2 = clr;
    @(posedge clk); #1;
    clr_cnt2 = 1'b0;
  endtask

  int stream_idx[4] = '{0, 1, 9, 10};
  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    tv[0]  = '{8'hA5, 5'h03, 8'hA5, 1'b0, 1'b0, 4'd0};
    tv[1]  = '{8'hAD, 5'h03, 8'hA5, 1'b1, 1'b0, 4'd7};
    tv[2]  = '{8'hA5, 5'h13, 8'hA5, 1'b1, 1'b0, 4'd0};
    tv[3]  = '{8'hA6, 5'h03, 8'hA6, 1'b0, 1'b1, 4'd6};
    tv[4]  = '{8'hA5, 5'h02, 8'hA5, 1'b1, 1'b0, 4'd1};
    tv[5]  = '{8'hA5, 5'h0B, 8'hA5, 1'b1, 1'b0, 4'd8};
    tv[6]  = '{8'h25, 5'h03, 8'hA5, 1'b1, 1'b0, 4'd12};
    tv[7]  = '{8'hB5, 5'h03, 8'hA5, 1'b1, 1'b0, 4'd9};
    tv[8]  = '{8'hA5, 5'h0E, 8'hA5, 1'b0, 1'b1, 4'd13};
    tv[9]  = '{8'h00, 5'h00, 8'h00, 1'b0, 1'b0, 4'd0};
    tv[10] = '{8'hFB, 5'h03, 8'hFF, 1'b1, 1'b0, 4'd6};
    tv[11] = '{8'hA4, 5'h13, 8'hA4, 1'b0, 1'b1, 4'd3};

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_single_cnt", single_cnt, 0);
    chk("rst_double_cnt", double_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 12; i++) apply1(i);

    // Back-pressure: four words against a stalled output
    begin
      int sent = 0;
      int got = 0;
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
        @(posedge clk); #1;
        if (cyc == 6) out_ready = 1'b1;
        in_valid = (sent < 4);
        in_data  = tv[stream_idx[sent < 4 ? sent : 0]].d;
        in_check = tv[stream_idx[sent < 4 ? sent : 0]].c;
        #1;
        if (cyc == 4) begin
          chk("t4_accepted_two", sent, 2);
          chk("t4_in_ready_low", in_ready, 0);
          chk("t4_held_valid", out_valid, 1);
          chk("t4_held_data", out_data, 8'hA5);
        end
        if (out_valid && out_ready) begin
          chk($sformatf("t4_word%0d", got), out_data, tv[stream_idx[got]].exp_d);
          exp_sc += int'(tv[stream_idx[got]].exp_s);
          got++;
        end
        if (in_valid && in_ready) sent++;
      end
      in_valid = 1'b0;
      chk("t4_all_out", got, 4);
      @(posedge clk); #1;
      chk("t4_no_duplicate", out_valid, 0);
      chk("t4_single_cnt", single_cnt, exp_sc);
    end

    // Saturation and clear on the 2-bit counter instance
    for (int k = 0; k < 5; k++) begin
      pass2(1'b0);
      chk($sformatf("t5_sat%0d", k), single_cnt2, sat_exp[k]);
    end
    pass2(1'b1);
    chk("t5_clr_wins", single_cnt2, 0);
    @(posedge clk); #1;
    chk("t5_clr_stays", single_cnt2, 0);

    // Asynchronous reset with both stages holding words
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = tv[1].d; in_check = tv[1].c;
    @(posedge clk); #1;
    in_data = tv[3].d; in_check = tv[3].c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t6_full_valid", out_valid, 1);
    chk("t6_full_blocked", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_single_cnt", single_cnt, 0);
    chk("t6_rst_double_cnt", double_cnt, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_single", out_single, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("t6_no_stale_word", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
